// File: rtl/char_sequencer.sv
// Character sequencer: captures a packed string on a ready edge and shows it one char per PERIOD cycles.
// Optional macro CHAR_SEQUENCER_LOOP_EN: restart from char 0 at sequence end instead of going idle.
module char_sequencer #(
  parameter int unsigned        CHAR_W    = 7,
  parameter int unsigned        NUM_CHARS = 11,
  parameter int unsigned        PERIOD    = 25000000,
  parameter logic [CHAR_W-1:0]  BLANK     = '1,
  localparam int unsigned       IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
  localparam int unsigned       CNT_W     = $clog2(PERIOD),
  localparam int unsigned       STR_W     = CHAR_W * NUM_CHARS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic [STR_W-1:0]   string_in,
  output logic [CHAR_W-1:0]  char_out,
  output logic [IDX_W-1:0]   char_idx,
  output logic               char_strobe,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t              state_q, state_d;
  logic [STR_W-1:0]    str_q, str_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q;
  logic [CHAR_W-1:0]   char_d;
  logic [IDX_W-1:0]    idx_d;
  logic                strobe_d, busy_d, done_d;
  logic                load_c;
  logic [IDX_W:0]      idx_nxt;
  logic [CHAR_W-1:0]   char_nxt;
  logic [CHAR_W-1:0]   char0_in;

  // Character k of a packed string; out-of-range indices read as a terminator.
  function automatic logic [CHAR_W-1:0] char_at(input logic [STR_W-1:0] s,
                                                input logic [IDX_W:0]   k);
    logic [CHAR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (k == (IDX_W+1)'(i)) r = s[STR_W-1-CHAR_W*i -: CHAR_W];
    end
    return r;
  endfunction

  assign load_c   = ready & ~ready_q;
  assign char0_in = string_in[STR_W-1 -: CHAR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      str_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      char_out    <= BLANK;
      char_idx    <= '0;
      char_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      str_q       <= str_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready;
      char_out    <= char_d;
      char_idx    <= idx_d;
      char_strobe <= strobe_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next state and next registered outputs; a load overrides any pending advance.
  always_comb begin
    state_d  = state_q;
    str_d    = str_q;
    cnt_d    = cnt_q;
    char_d   = char_out;
    idx_d    = char_idx;
    strobe_d = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    idx_nxt  = (IDX_W+1)'(char_idx) + (IDX_W+1)'(1);
    char_nxt = char_at(str_q, idx_nxt);

    if (load_c) begin
      str_d = string_in;
      cnt_d = '0;
      if (char0_in != '0) begin
        char_d   = char0_in;
        idx_d    = '0;
        strobe_d = 1'b1;
        busy_d   = 1'b1;
        state_d  = SHOW;
      end else begin
        char_d   = BLANK;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end else if (state_q == SHOW) begin
      if (cnt_q == CNT_W'(PERIOD - 1)) begin
        cnt_d = '0;
        if ((idx_nxt < (IDX_W+1)'(NUM_CHARS)) && (char_nxt != '0)) begin
          char_d   = char_nxt;
          idx_d    = IDX_W'(idx_nxt);
          strobe_d = 1'b1;
        end else begin
          done_d = 1'b1;
`ifdef CHAR_SEQUENCER_LOOP_EN
          // Char 0 of a stored string is always nonzero, otherwise SHOW is never entered.
          char_d   = str_q[STR_W-1 -: CHAR_W];
          idx_d    = '0;
          strobe_d = 1'b1;
`else
          char_d   = BLANK;
          busy_d   = 1'b0;
          state_d  = IDLE;
`endif
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_char_sequencer.sv
// Scoreboard bench for char_sequencer with CHAR_W=7, NUM_CHARS=4, PERIOD=4.
module tb_char_sequencer;

  localparam int CW  = 7;
  localparam int NC  = 4;
  localparam int PER = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic [27:0]   string_in;
  logic [6:0]    char_out;
  logic [1:0]    char_idx;
  logic          char_strobe;
  logic          busy;
  logic          done;

  char_sequencer #(.CHAR_W(CW), .NUM_CHARS(NC), .PERIOD(PER)) dut (
    .clk(clk), .reset(reset), .ready(ready), .string_in(string_in),
    .char_out(char_out), .char_idx(char_idx), .char_strobe(char_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [6:0] ch; logic [1:0] idx;} sev_t;
  typedef struct {int cyc; logic [6:0] ch; logic bsy;} dev_t;

  sev_t sq[$];
  dev_t dq[$];
  sev_t se;
  dev_t de;
  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  // Output monitor: every strobe and done must match the head of its expectation queue.
  always @(negedge clk) begin
    if (char_strobe) begin
      strobe_cnt++;
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d char_out=%h idx=%0d required no strobe", cyc, char_out, char_idx);
      end else begin
        se = sq.pop_front();
        if (cyc !== se.cyc || char_out !== se.ch || char_idx !== se.idx) begin
          errors++;
          $display("FAIL strobe cyc=%0d char=%h idx=%0d required cyc=%0d char=%h idx=%0d",
                   cyc, char_out, char_idx, se.cyc, se.ch, se.idx);
        end
      end
    end
    if (done) begin
      done_cnt++;
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d required no done", cyc);
      end else begin
        de = dq.pop_front();
        if (cyc !== de.cyc || char_out !== de.ch || busy !== de.bsy) begin
          errors++;
          $display("FAIL done cyc=%0d char=%h busy=%b required cyc=%0d char=%h busy=%b",
                   cyc, char_out, busy, de.cyc, de.ch, de.bsy);
        end
      end
    end
`ifndef CHAR_SEQUENCER_LOOP_EN
    if (char_strobe || done) begin
      checks++;
      if ((char_strobe && done) !== 1'b0) begin
        errors++;
        $display("FAIL strobe_done_overlap cyc=%0d got both high required exclusive", cyc);
      end
    end
`endif
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-shot expectations for a load at edge t.
  task automatic push_load(input logic [27:0] s, input int t);
    int len;
    logic [6:0] ch;
    len = NC;
    for (int k = 0; k < NC; k++) begin
      ch = s[27-7*k -: 7];
      if (ch == 7'h00 && len == NC) len = k;
    end
    for (int k = 0; k < len; k++) begin
      ch = s[27-7*k -: 7];
      sq.push_back('{t + k*PER, ch, 2'(k)});
    end
    dq.push_back('{t + len*PER, 7'h7F, 1'b0});
  endtask

  // Called at a negedge with ready low; the load happens on the next edge.
  task automatic do_load(input logic [27:0] s, output int t);
    ready     = 1'b1;
    string_in = s;
    t         = cyc + 1;
`ifndef CHAR_SEQUENCER_LOOP_EN
    push_load(s, t);
`endif
  endtask

  task automatic test_reset;
    int s0, d0;
    repeat (3) @(negedge clk);
    checks++;
    if (char_out !== 7'h7F || char_idx !== 2'd0 || char_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values char=%h idx=%0d strobe=%b busy=%b done=%b required 7f 0 0 0 0",
               char_out, char_idx, char_strobe, busy, done);
    end
    reset = 1'b0;
    s0 = strobe_cnt;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 !== 0 || done_cnt - d0 !== 0 || char_out !== 7'h7F || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle strobes=%0d dones=%0d char=%h busy=%b required 0 0 7f 0",
               strobe_cnt - s0, done_cnt - d0, char_out, busy);
    end
  endtask

  task automatic test_full;
    int t, s0, d0;
    @(negedge clk);
    s0 = strobe_cnt;
    d0 = done_cnt;
    do_load({7'h11, 7'h22, 7'h33, 7'h44}, t);
    wait_until(t + 1);
    checks++;
    if (busy !== 1'b1 || char_out !== 7'h11) begin
      errors++;
      $display("FAIL full_start busy=%b char=%h required 1 11", busy, char_out);
    end
    wait_until(t + NC*PER + 1);
    checks++;
    if (strobe_cnt - s0 !== 4 || done_cnt - d0 !== 1 || sq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL full_counts strobes=%0d dones=%0d pend=%0d/%0d required 4 1 0/0",
               strobe_cnt - s0, done_cnt - d0, sq.size(), dq.size());
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || char_out !== 7'h7F) begin
      errors++;
      $display("FAIL full_after done=%b busy=%b char=%h required 0 0 7f", done, busy, char_out);
    end
    ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_terminator;
    int t, s0, d0, busy_hi;
    s0 = strobe_cnt;
    d0 = done_cnt;
    do_load({7'h11, 7'h22, 7'h00, 7'h44}, t);
    wait_until(t + 14);
    checks++;
    if (strobe_cnt - s0 !== 2 || done_cnt - d0 !== 1 || sq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL term_counts strobes=%0d dones=%0d pend=%0d/%0d required 2 1 0/0",
               strobe_cnt - s0, done_cnt - d0, sq.size(), dq.size());
    end
    ready = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    busy_hi = 0;
    do_load({7'h00, 7'h22, 7'h33, 7'h44}, t);
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    checks++;
    if (busy_hi !== 0 || done_cnt - d0 !== 1 || dq.size() !== 0) begin
      errors++;
      $display("FAIL term_zero busy_cycles=%0d dones=%0d pend=%0d required 0 1 0",
               busy_hi, done_cnt - d0, dq.size());
    end
    ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart;
    int t, t2, s0, d0;
    s0 = strobe_cnt;
    d0 = done_cnt;
    do_load({7'h11, 7'h22, 7'h33, 7'h44}, t);
    wait_until(t + 4);
    ready = 1'b0;
    @(negedge clk);
    sq.delete();
    dq.delete();
    do_load({7'h55, 7'h66, 7'h00, 7'h00}, t2);
    checks++;
    if (t2 !== t + 6) begin
      errors++;
      $display("FAIL restart_edge t2=%0d required %0d", t2, t + 6);
    end
    wait_until(t2 + 20);
    checks++;
    if (strobe_cnt - s0 !== 4 || done_cnt - d0 !== 1 || sq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL restart_counts strobes=%0d dones=%0d pend=%0d/%0d required 4 1 0/0",
               strobe_cnt - s0, done_cnt - d0, sq.size(), dq.size());
    end
    ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int t, d0;
    do_load({7'h11, 7'h22, 7'h33, 7'h44}, t);
    wait_until(t + 4);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    checks++;
    if (char_out !== 7'h7F || char_idx !== 2'd0 || char_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid char=%h idx=%0d strobe=%b busy=%b done=%b required 7f 0 0 0 0",
               char_out, char_idx, char_strobe, busy, done);
    end
    sq.delete();
    dq.delete();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after dones=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
  endtask

`ifdef CHAR_SEQUENCER_LOOP_EN
  task automatic test_loop;
    int t;
    logic [27:0] s;
    logic [6:0] ch;
    s = {7'h11, 7'h22, 7'h33, 7'h44};
    do_load(s, t);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NC; k++) begin
        ch = s[27-7*k -: 7];
        sq.push_back('{t + p*NC*PER + k*PER, ch, 2'(k)});
      end
      dq.push_back('{t + (p+1)*NC*PER, 7'h11, 1'b1});
    end
    sq.push_back('{t + 2*NC*PER, 7'h11, 2'd0});
    wait_until(t + NC*PER);
    checks++;
    if (done !== 1'b1 || char_out !== 7'h11 || char_idx !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL loop_wrap done=%b char=%h idx=%0d busy=%b required 1 11 0 1",
               done, char_out, char_idx, busy);
    end
    wait_until(t + 2*NC*PER);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (sq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL loop_pending strobes=%0d dones=%0d required 0 0", sq.size(), dq.size());
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    ready     = 1'b0;
    string_in = '0;
    test_reset();
`ifdef CHAR_SEQUENCER_LOOP_EN
    test_loop();
`else
    test_full();
    test_terminator();
    test_restart();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_sequencer.md
# char_sequencer

Parametrised character sequencer for the POV receiver path. On a rising edge of `ready` it captures a packed string of `NUM_CHARS` characters and presents them on `char_out` one at a time, each held for `PERIOD` clock cycles. It stops at the first all-zero character or after the last character. It adds busy/done/strobe status, a character index and restart-on-reload, and can optionally loop.

## Interface
- `CHAR_W`, 7: bits per character.
- `NUM_CHARS`, 11: characters per string (≥1).
- `PERIOD`, 25000000: cycles each character is held (≥2).
- `BLANK`, all-ones of `CHAR_W`: idle/blank code driven on `char_out`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `ready`  in  1  load request; a 0→1 transition (sampled) starts a sequence.
- `string_in`  in  `CHAR_W*NUM_CHARS`  packed string; char 0 in the MSBs `[CHAR_W*NUM_CHARS-1 -: CHAR_W]`, char k follows.
- `char_out`  out  `CHAR_W`  current character, registered.
- `char_idx`  out  `$clog2(NUM_CHARS)` (min 1)  index of character on `char_out`.
- `char_strobe`  out  1  one-cycle pulse on each `char_out` update with a real character.
- `busy`  out  1  high while a sequence is displaying.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- Reset values: `char_out`=BLANK, `char_idx`=0, `char_strobe`=0, `busy`=0, `done`=0. Internal shift register, hold counter and `ready_q` are 0.
- Edge detect: `ready_q` registers `ready`. A load occurs on a clock edge where `ready`=1 and `ready_q`=0. If `ready` is held high out of reset, one load occurs on the first edge. Holding `ready` high never re-triggers.
- States: IDLE, SHOW.
- Load, from either state: capture `string_in`. Evaluate char 0:
  - If nonzero: `char_out`←char0, `char_idx`←0, `char_strobe`←1, `busy`←1, counter←0, go to SHOW.
  - If zero: `char_out`←BLANK, `busy`←0, `done`←1, stay in or go to IDLE.
- SHOW: the counter increments each cycle. When counter = PERIOD-1, the counter clears and the sequencer advances to char k+1:
  - If k+1 < NUM_CHARS and char k+1 ≠ 0: show it, `char_idx`←k+1, `char_strobe`←1.
  - Otherwise: `char_out`←BLANK, `busy`←0, `done`←1, go to IDLE.
- A load while busy aborts the current sequence with no `done` and restarts with the new string. A load takes priority over an advance on the same edge.
- Zero characters after the terminator are ignored. The terminator itself is never shown.
- Reset mid-sequence returns to reset values on that edge, with no `done`.

## Timing
- Load at edge T: char 0 is visible after edge T. Char k is visible after edge T+k·PERIOD.
- A full string ends at edge T+NUM_CHARS·PERIOD: BLANK shown, `busy` falls and `done` pulses on the same edge.
- A terminator at index k ends the sequence at edge T+k·PERIOD.
- `char_strobe` and `done` are exactly one cycle wide and never high together.
- Counter width is `$clog2(PERIOD)`; it never exceeds PERIOD-1.

## Configuration
- `CHAR_SEQUENCER_LOOP_EN` defined:
  - At sequence end the sequencer does not go IDLE.
  - `done` pulses, and on the same edge char 0 of the stored string is shown again, `char_idx`←0, `char_strobe`←1, `busy` stays 1.
  - It repeats until reset or a new load.
  - A zero char 0 still ends immediately as in one-shot mode.
- `CHAR_SEQUENCER_LOOP_EN` undefined: one-shot behaviour as above.
- With the macro defined, `done` and `char_strobe` may be high together on the wrap edge.

## Test plan
All tests use CHAR_W=7, NUM_CHARS=4, PERIOD=4.
- Reset then idle: `char_out`=7'h7F, `busy`=0, `done`=0. Holding `ready`=0 for 20 cycles produces no strobes.
- Full string {A,B,C,D} = 7'h11,22,33,44, `ready` 0→1 at edge T:
  - 11/22/33/44 appear after T, T+4, T+8, T+12, with `char_idx` 0..3 and 4 strobes.
  - At T+16: 7'h7F, `busy` 0, `done` pulses one cycle.
- Terminator: string {11,22,00,44}:
  - 11 and 22 shown; at T+8 BLANK and `done`.
  - 44 is never shown.
  - A zero char 0 gives `done` at T with `busy` never high.
- Restart: second `ready` edge at T+6 with {55,66,00,00}:
  - 55 after T+6, 66 after T+10, end at T+14.
  - Only one `done` pulse in total; `ready` held high produces no second load.
- Reset at T+5: all outputs return to reset values after that edge, with no `done`.
- With `CHAR_SEQUENCER_LOOP_EN`, full string: at T+16 `done`=1, `char_out`=11, `char_idx`=0 and `busy`=1. The pattern repeats at T+32.
